// File: rtl/pe_array_3x3_pkg.sv
// Shared constants and flat-bus offset helpers for the 3x3 PE array.
package pe_array_3x3_pkg;

    localparam int DATA_W    = 16;
    localparam int IFMAP_DIM = 5;
    localparam int FILT_DIM  = 3;
    localparam int OUT_DIM   = IFMAP_DIM - FILT_DIM + 1;
    localparam int COL_W     = 2;

    // Bit offset of ifmap element (r,c) within the flat ifmap bus
    function automatic int ifmap_off(input int r, input int c);
        return (r * IFMAP_DIM + c) * DATA_W;
    endfunction

    // Bit offset of weight (i,j) within the flat filter bus
    function automatic int filt_off(input int i, input int j);
        return (i * FILT_DIM + j) * DATA_W;
    endfunction

    // Bit offset of result (y,x) within the flat output bus
    function automatic int out_off(input int y, input int x);
        return (y * OUT_DIM + x) * DATA_W;
    endfunction

endpackage

// File: rtl/pe_array_3x3_pe_row.sv
// One PE: three multipliers forming a 1D partial sum of a filter row
// against a 3-wide window of an ifmap row, window start selected by col.
module pe_row
    import pe_array_3x3_pkg::*;
(
    input  logic [FILT_DIM-1:0][DATA_W-1:0]  filt_row,
    input  logic [IFMAP_DIM-1:0][DATA_W-1:0] ifmap_row,
    input  logic [COL_W-1:0]                 col,
    output logic [DATA_W-1:0]                psum
);

    logic [FILT_DIM-1:0][DATA_W-1:0] win;

    // Window select and multiply-accumulate; products and sum wrap at DATA_W bits.
    // col==3 cannot be held by the counter, but maps to window 0 rather than
    // reading past the end of the row.
    always_comb begin
        win  = '0;
        psum = '0;
        for (int j = 0; j < FILT_DIM; j++) begin
            case (col)
                2'd1:    win[j] = ifmap_row[j + 1];
                2'd2:    win[j] = ifmap_row[j + 2];
                default: win[j] = ifmap_row[j];
            endcase
            psum = psum + filt_row[j] * win[j];
        end
    end

endmodule

// File: rtl/pe_array_3x3.sv
// Row-stationary 3x3 convolution core: 9 PEs, per-column adder chains,
// a column counter, and 9 output registers filled one output column per
// enabled clock.
module pe_array_3x3
    import pe_array_3x3_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [IFMAP_DIM*IFMAP_DIM*DATA_W-1:0] ifmap_in_flat,
    input  logic [FILT_DIM*FILT_DIM*DATA_W-1:0]   filter_in_flat,
    output logic [OUT_DIM*OUT_DIM*DATA_W-1:0]     sum_out_flat
);

    logic [COL_W-1:0]                          col;
    logic [OUT_DIM-1:0][FILT_DIM-1:0][DATA_W-1:0] psum;   // [y][i]
    logic [OUT_DIM-1:0][DATA_W-1:0]            colsum;    // [y]
    logic [OUT_DIM-1:0][OUT_DIM-1:0][DATA_W-1:0] sum_q;   // [y][x]

    // PE(i,y): filter row i against ifmap row y+i
    for (genvar i = 0; i < FILT_DIM; i++) begin : g_row
        for (genvar y = 0; y < OUT_DIM; y++) begin : g_col
            pe_row u_pe (
                .filt_row  (filter_in_flat[filt_off(i, 0) +: FILT_DIM*DATA_W]),
                .ifmap_row (ifmap_in_flat[ifmap_off(y + i, 0) +: IFMAP_DIM*DATA_W]),
                .col       (col),
                .psum      (psum[y][i])
            );
        end
    end

    // Vertical reduction of the three PE partial sums in each array column
    always_comb begin
        colsum = '0;
        for (int y = 0; y < OUT_DIM; y++) begin
            colsum[y] = psum[y][0] + psum[y][1] + psum[y][2];
        end
    end

    // Column counter and output registers; one output column written per enabled edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col   <= '0;
            sum_q <= '0;
        end else if (en) begin
            for (int y = 0; y < OUT_DIM; y++) begin
                for (int x = 0; x < OUT_DIM; x++) begin
                    if (col == COL_W'(x)) sum_q[y][x] <= colsum[y];
                end
            end
            col <= (col >= COL_W'(OUT_DIM - 1)) ? '0 : col + 1'b1;
        end
    end

    assign sum_out_flat = sum_q;

endmodule

// File: tb/tb_pe_array_3x3.sv
// Scoreboard bench for pe_array_3x3: the driver pushes the expected output map
// after each stimulus step, a negedge monitor pops and compares.
module tb_pe_array_3x3;

    localparam int W  = 16;
    localparam int MW = 144;

    typedef struct {
        string          name;
        logic [MW-1:0]  exp;
    } sb_item_t;

    // Hand-computed maps, element (y,x) at bits [(y*3+x)*16 +: 16]
    localparam logic [MW-1:0] ZERO = '0;
    localparam logic [MW-1:0] BOX  = {16'h00AB, 16'h00A2, 16'h0099, 16'h007E, 16'h0075,
                                      16'h006C, 16'h0051, 16'h0048, 16'h003F};
    localparam logic [MW-1:0] IDN  = {16'd19, 16'd18, 16'd17, 16'd14, 16'd13,
                                      16'd12, 16'd9, 16'd8, 16'd7};
    localparam logic [MW-1:0] NEG  = {16'hFF55, 16'hFF5E, 16'hFF67, 16'hFF82, 16'hFF8B,
                                      16'hFF94, 16'hFFAF, 16'hFFB8, 16'hFFC1};
    localparam logic [MW-1:0] WRAP = {9{16'hFFEE}};

    logic            clk;
    logic            rst;
    logic            en;
    logic [399:0]    ifmap_in_flat;
    logic [143:0]    filter_in_flat;
    logic [143:0]    sum_out_flat;

    sb_item_t sb_q[$];
    int       n_vec;
    int       n_miss;

    pe_array_3x3 dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .ifmap_in_flat  (ifmap_in_flat),
        .filter_in_flat (filter_in_flat),
        .sum_out_flat   (sum_out_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Columns set in mask come from n, others from o
    function automatic logic [MW-1:0] mix(input logic [MW-1:0] n, input logic [MW-1:0] o,
                                          input logic [2:0] mask);
        logic [MW-1:0] r;
        r = o;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                if (mask[x]) r[(y*3+x)*W +: W] = n[(y*3+x)*W +: W];
        return r;
    endfunction

    task automatic expect_map(input string name, input logic [MW-1:0] e);
        sb_item_t it;
        it.name = name;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    // One enabled/disabled edge, then queue the expected map
    task automatic step(input string name, input logic [MW-1:0] e);
        @(posedge clk);
        #1;
        expect_map(name, e);
    endtask

    task automatic set_box_ifmap();
        for (int k = 0; k < 25; k++) ifmap_in_flat[k*W +: W] = W'(k + 1);
    endtask

    task automatic set_filter_all(input logic [W-1:0] v);
        for (int k = 0; k < 9; k++) filter_in_flat[k*W +: W] = v;
    endtask

    task automatic set_filter_identity();
        filter_in_flat = '0;
        filter_in_flat[4*W +: W] = 16'd1;
    endtask

    // Monitor: compare the registered output map away from the active edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            n_vec++;
            if (sum_out_flat !== it.exp) begin
                n_miss++;
                $display("FAIL %s: got %h expected %h", it.name, sum_out_flat, it.exp);
            end
        end
    end

    initial begin
        int guard;
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b0;
        en     = 1'b1;
        for (int k = 0; k < 25; k++) ifmap_in_flat[k*W +: W] = W'($urandom);
        for (int k = 0; k < 9; k++) filter_in_flat[k*W +: W] = W'($urandom);

        // Held reset with random operands and running clock
        repeat (3) step("reset_hold", ZERO);

        // Box sum: partial fill then full map
        set_box_ifmap();
        set_filter_all(16'd1);
        rst = 1'b1;
        step("box_edge1", mix(BOX, ZERO, 3'b001));
        step("box_edge2", mix(BOX, ZERO, 3'b011));
        step("box_full",  BOX);

        // Mid-pass filter change to identity after edge 1 of a new pass
        step("midchg_edge1", BOX);
        set_filter_identity();
        step("midchg_edge2", mix(IDN, BOX, 3'b010));
        step("midchg_edge3", mix(IDN, BOX, 3'b110));
        step("midchg_full",  IDN);

        // Realign to column 0, then enable hold with negative weights
        step("idn_keep1", IDN);
        step("idn_keep2", IDN);
        set_filter_all(16'hFFFF);
        step("neg_edge1", mix(NEG, IDN, 3'b001));
        en = 1'b0;
        for (int k = 0; k < 5; k++) step("en_hold", mix(NEG, IDN, 3'b001));
        en = 1'b1;
        step("neg_edge2", mix(NEG, IDN, 3'b011));
        step("neg_full",  NEG);

        // Wraparound: 0x7FFF * 2 summed nine times
        for (int k = 0; k < 25; k++) ifmap_in_flat[k*W +: W] = 16'h7FFF;
        set_filter_all(16'd2);
        step("wrap_edge1", mix(WRAP, NEG, 3'b001));
        step("wrap_edge2", mix(WRAP, NEG, 3'b011));
        step("wrap_full",  WRAP);

        // Asynchronous reset in the middle of a pass
        set_box_ifmap();
        set_filter_all(16'd1);
        step("pre_rst_edge1", mix(BOX, WRAP, 3'b001));
        step("pre_rst_edge2", mix(BOX, WRAP, 3'b011));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 expect_map("async_rst", ZERO);
        step("rst_held", ZERO);
        rst = 1'b1;
        step("restart_col0", mix(BOX, ZERO, 3'b001));
        step("restart_col1", mix(BOX, ZERO, 3'b011));
        step("restart_full", BOX);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
